// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline.
// Turns the M-stage load/store into one word transaction on a valid/ready
// data bus. It holds the pipeline with stall_m while the access is in flight
// and registers load data into rd_dmw for W-stage writeback. Misaligned
// accesses and dead slaves are reported as one-cycle error pulses, so the
// core never hangs.
module mem_stage #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_m,
    input  logic        we_dmm,
    input  logic [31:0] alu_outm,
    input  logic [31:0] wd_dmm,
    output logic        stall_m,
    output logic [31:0] rd_dmw,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    // The counter only has to reach TIMEOUT-1. One spare bit keeps the
    // compare simple when TIMEOUT is an exact power of two.
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] timeoutCnt_q, timeoutCnt_d;
    logic          busValid_q, busValid_d;
    logic          busWe_q, busWe_d;
    logic [31:0]   busAddr_q, busAddr_d;
    logic [31:0]   busWdata_q, busWdata_d;
    logic [31:0]   rdData_q, rdData_d;
    logic          addrErr_q, addrErr_d;
    logic          busErr_q, busErr_d;

    logic          accepted;
    logic          timeoutHit;
    logic          completion;
    logic          misalignedIdle;

    assign accepted   = busValid_q && bus_ready;
    assign timeoutHit = (timeoutCnt_q == CNT_LAST);

    // Next-state logic: request launch, acceptance, response capture and abort on timeout.
    always_comb begin
        state_d        = state_q;
        timeoutCnt_d   = timeoutCnt_q;
        busValid_d     = busValid_q;
        busWe_d        = busWe_q;
        busAddr_d      = busAddr_q;
        busWdata_d     = busWdata_q;
        rdData_d       = rdData_q;
        addrErr_d      = 1'b0;
        busErr_d       = 1'b0;
        completion     = 1'b0;
        misalignedIdle = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req_m) begin
                    if (alu_outm[1:0] != 2'b00) begin
                        misalignedIdle = 1'b1;
                        addrErr_d      = 1'b1;
                        if (!we_dmm) begin
                            rdData_d = ERR_DATA;
                        end
                    end else begin
                        busAddr_d    = {alu_outm[31:2], 2'b00};
                        busWdata_d   = wd_dmm;
                        busWe_d      = we_dmm;
                        busValid_d   = 1'b1;
                        timeoutCnt_d = '0;
                        state_d      = REQ;
                    end
                end
            end

            REQ: begin
                timeoutCnt_d = timeoutCnt_q + 1'b1;
                if (accepted && busWe_q) begin
                    completion = 1'b1;
                    busValid_d = 1'b0;
                    state_d    = IDLE;
                end else if (timeoutHit) begin
                    // An accepted load still needs its response, so the
                    // access has not completed and the abort goes ahead.
                    completion = 1'b1;
                    busValid_d = 1'b0;
                    busErr_d   = 1'b1;
                    if (!busWe_q) begin
                        rdData_d = ERR_DATA;
                    end
                    state_d = IDLE;
                end else if (accepted) begin
                    busValid_d = 1'b0;
                    state_d    = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                timeoutCnt_d = timeoutCnt_q + 1'b1;
                if (bus_rvalid) begin
                    completion = 1'b1;
                    rdData_d   = bus_rdata;
                    state_d    = IDLE;
                end else if (timeoutHit) begin
                    completion = 1'b1;
                    busErr_d   = 1'b1;
                    rdData_d   = ERR_DATA;
                    state_d    = IDLE;
                end
            end

            default: begin
                busValid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers. A reset drops any outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timeoutCnt_q <= '0;
            busValid_q   <= 1'b0;
            busWe_q      <= 1'b0;
            busAddr_q    <= '0;
            busWdata_q   <= '0;
            rdData_q     <= '0;
            addrErr_q    <= 1'b0;
            busErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
            busValid_q   <= busValid_d;
            busWe_q      <= busWe_d;
            busAddr_q    <= busAddr_d;
            busWdata_q   <= busWdata_d;
            rdData_q     <= rdData_d;
            addrErr_q    <= addrErr_d;
            busErr_q     <= busErr_d;
        end
    end

    assign stall_m   = mem_req_m && !completion && !misalignedIdle;
    assign rd_dmw    = rdData_q;
    assign addr_err  = addrErr_q;
    assign bus_err   = busErr_q;
    assign bus_valid = busValid_q;
    assign bus_we    = busWe_q;
    assign bus_addr  = busAddr_q;
    assign bus_wdata = busWdata_q;

endmodule
